// File: rtl/mult_div_unit_if.sv
// Request/response bundle for the multiply/divide unit: operation launch,
// HI/LO moves, status flags and the architectural HI/LO values.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers:
// one bit per cycle, 32 iterations, sign fix-up applied on the final edge.
module mult_div_unit (
    input  logic          clock,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ITERS = 32;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q;
    logic [W-1:0]       a_q, b_q;
    logic [2*W-1:0]     acc_q, acc_step, acc_init, prod;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, dbz_q, busy_d, done_d, dbz_d;
    logic [W-1:0]       hi_q, lo_q, res_hi, res_lo;
    logic [W-1:0]       mag_a, mag_b, in_mag_a, in_mag_b, quo, rem;
    logic [W:0]         sum, trial;
    logic               is_div, neg_a, neg_b, div_zero, last_iter, in_signed;

    // Operand decode: op[0]=1 means unsigned, op[1]=1 means divide
    assign is_div    = op_q[1];
    assign neg_a     = ~op_q[0] & a_q[W-1];
    assign neg_b     = ~op_q[0] & b_q[W-1];
    assign mag_a     = neg_a ? W'(-a_q) : a_q;
    assign mag_b     = neg_b ? W'(-b_q) : b_q;
    assign div_zero  = is_div && (b_q == '0);
    assign last_iter = (cnt_q == CNT_W'(ITERS - 1));

    // Accumulator seed taken straight from the inputs on the start edge
    assign in_signed = ~bus.op[0];
    assign in_mag_a  = (in_signed & bus.rs_data[W-1]) ? W'(-bus.rs_data) : bus.rs_data;
    assign in_mag_b  = (in_signed & bus.rt_data[W-1]) ? W'(-bus.rt_data) : bus.rt_data;
    assign acc_init  = bus.op[1] ? {W'(0), in_mag_a} : {W'(0), in_mag_b};

    // One iteration: shift-add multiply (right shift) or restoring divide (left shift)
    always_comb begin
        sum      = '0;
        trial    = '0;
        acc_step = acc_q;
        if (is_div) begin
            trial = acc_q[2*W-1:W-1] - {1'b0, mag_b};
            if (!trial[W])
                acc_step = {trial[W-1:0], acc_q[W-2:0], 1'b1};
            else
                acc_step = {acc_q[2*W-2:0], 1'b0};
        end else begin
            sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mag_a} : (W+1)'(0));
            acc_step = {sum, acc_q[W-1:1]};
        end
    end

    // Sign fix-up; remainder follows the dividend so division truncates toward zero
    always_comb begin
        quo    = acc_step[W-1:0];
        rem    = acc_step[2*W-1:W];
        prod   = (neg_a ^ neg_b) ? (2*W)'(-acc_step) : acc_step;
        res_hi = prod[2*W-1:W];
        res_lo = prod[W-1:0];
        if (is_div) begin
            res_lo = (neg_a ^ neg_b) ? W'(-quo) : quo;
            res_hi = neg_a ? W'(-rem) : rem;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = BUSY;
            BUSY:    if (div_zero || last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
        dbz_d  = (state_d == DONE) && div_zero;
    end

    // Status flags, operand capture, iteration and HI/LO update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    op_q  <= bus.op;
                    a_q   <= bus.rs_data;
                    b_q   <= bus.rt_data;
                    acc_q <= acc_init;
                    cnt_q <= '0;
                end else begin
                    if (bus.mthi) hi_q <= bus.rs_data;
                    if (bus.mtlo) lo_q <= bus.rs_data;
                end
            end else if (state_q == BUSY && !div_zero) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CNT_W'(1);
                if (last_iter) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for the arithmetic plus
// hand sequences for moves, divide-by-zero and mid-operation reset.
module tb_mult_div_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps edges until done is seen; edges counts from the start edge (=1)
    task automatic wait_done(inout int edges, inout int busy_cycles, output bit timeout);
        timeout = 1'b1;
        while (edges < 60) begin
            if (bus.done) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clock); #1;
            edges++;
            busy_cycles += int'(bus.busy);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cycles, output bit timeout);
        bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
        @(posedge clock); #1;
        edges = 1;
        busy_cycles = int'(bus.busy);
        // scramble inputs: latched operands must be unaffected
        bus.start = 1'b0; bus.op = ~op; bus.rs_data = ~a; bus.rt_data = ~b;
        wait_done(edges, busy_cycles, timeout);
    endtask

    initial begin
        vec_t vecs [10];
        int   edges, bcyc;
        bit   tmo;

        vecs[0] = '{MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[1] = '{MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[5] = '{MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'd15};
        vecs[6] = '{DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[7] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[8] = '{MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[9] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;

        // Reset state
        #12;
        check("reset_hi",   64'(bus.hi),          64'h0);
        check("reset_lo",   64'(bus.lo),          64'h0);
        check("reset_busy", 64'(bus.busy),        64'h0);
        check("reset_done", 64'(bus.done),        64'h0);
        check("reset_dbz",  64'(bus.div_by_zero), 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // mthi then DIVU 5/0: flag pulse after the single BUSY cycle, HI/LO kept
        bus.mthi = 1'b1; bus.rs_data = 32'h1234;
        @(posedge clock); #1;
        bus.mthi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        check("mthi_lo", 64'(bus.lo), 64'h0);
        run_op(DIVU, 32'd5, 32'd0, edges, bcyc, tmo);
        check("dbz_timeout", 64'(tmo), 64'h0);
        check("dbz_edges",   64'(edges), 64'd2);
        check("dbz_flag",    64'(bus.div_by_zero), 64'h1);
        check("dbz_hi",      64'(bus.hi), 64'h1234);
        check("dbz_lo",      64'(bus.lo), 64'h0);
        @(posedge clock); #1;
        check("dbz_done_pulse", 64'({bus.done, bus.div_by_zero}), 64'h0);

        // mthi+mtlo together load both registers
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.rs_data = 32'hA5A5_0F0F;
        @(posedge clock); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mv_both", {bus.hi, bus.lo}, 64'hA5A5_0F0F_A5A5_0F0F);

        // start with mtlo in the same cycle, then mtlo pulsed while BUSY
        bus.op = MULTU; bus.rs_data = 32'h55; bus.rt_data = 32'd4;
        bus.start = 1'b1; bus.mtlo = 1'b1;
        @(posedge clock); #1;
        edges = 1; bcyc = int'(bus.busy);
        bus.start = 1'b0;
        check("start_wins_lo", 64'(bus.lo), 64'hA5A5_0F0F);
        bus.rs_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            edges++; bcyc += int'(bus.busy);
        end
        check("mtlo_busy_lo", 64'(bus.lo), 64'hA5A5_0F0F);
        bus.mtlo = 1'b0;
        wait_done(edges, bcyc, tmo);
        check("mtlo_op_timeout", 64'(tmo), 64'h0);
        check("mtlo_op_lo", 64'(bus.lo), 64'h154);
        check("mtlo_op_hi", 64'(bus.hi), 64'h0);
        @(posedge clock); #1;

        // Arithmetic table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, bcyc, tmo);
            check($sformatf("v%0d_timeout", i), 64'(tmo), 64'h0);
            check($sformatf("v%0d_edges", i),   64'(edges), 64'd33);
            check($sformatf("v%0d_busy", i),    64'(bcyc), 64'd32);
            check($sformatf("v%0d_hi", i),      64'(bus.hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_lo", i),      64'(bus.lo), 64'(vecs[i].exp_lo));
            check($sformatf("v%0d_dbz", i),     64'(bus.div_by_zero), 64'h0);
            @(posedge clock); #1;
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'h0);
        end

        // Reset between edges at iteration 10 aborts without done
        bus.op = MULTU; bus.rs_data = 32'hFFFF_FFFF; bus.rt_data = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'h0);
        check("rst_mid_flags", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            edges += int'(bus.done) + int'(bus.busy);
        end
        check("rst_no_done", 64'(edges), 64'h0);
        run_op(MULTU, 32'd3, 32'd4, edges, bcyc, tmo);
        check("post_rst_timeout", 64'(tmo), 64'h0);
        check("post_rst_edges", 64'(edges), 64'd33);
        check("post_rst_lo", 64'(bus.lo), 64'd12);
        check("post_rst_hi", 64'(bus.hi), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have the port `clock`: input, 1 bit, rising-edge clock shared with the register file.
REQ-003 The block SHALL have the port `reset`: input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have the port `start`: input, 1 bit, begins an operation; sampled only in IDLE.
REQ-005 The block SHALL have the port `op`: input, 2 bits; 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
REQ-006 The block SHALL have the port `rs_data`: input, 32 bits, operand A (register file readData1); also the source for mthi/mtlo.
REQ-007 The block SHALL have the port `rt_data`: input, 32 bits, operand B (register file readData2).
REQ-008 The block SHALL have the port `mthi`: input, 1 bit, write HI from `rs_data`.
REQ-009 The block SHALL have the port `mtlo`: input, 1 bit, write LO from `rs_data`.
REQ-010 The block SHALL have the port `busy`: output, 1 bit, high while in state BUSY.
REQ-011 The block SHALL have the port `done`: output, 1 bit, one-cycle completion pulse.
REQ-012 The block SHALL have the port `div_by_zero`: output, 1 bit, pulses together with `done` when a DIV/DIVU has divisor 0.
REQ-013 The block SHALL have the ports `hi` and `lo`: outputs, 32 bits each, architectural HI/LO registers (feed the mfhi/mflo write-back path to the register file).

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, BUSY, DONE; all state and outputs registered.
REQ-015 In IDLE with `start`=1 at a rising edge, the block SHALL latch `op`, `rs_data` and `rt_data`, clear the iteration counter to 0, and go to BUSY.
REQ-016 The block SHALL ignore `start` in BUSY and DONE; the latched operands are unaffected by input changes after capture.
REQ-017 In BUSY, the block SHALL perform one iteration per edge: shift-add multiply or restoring divide, 1 bit per iteration, 6-bit counter.
REQ-018 After the 32nd BUSY edge, the block SHALL write HI/LO, go to DONE, and set `done`=1 for exactly one cycle.
REQ-019 From DONE, the next edge SHALL return the block to IDLE; `start` is first accepted again in IDLE, giving total latency start-edge-to-done = 33 edges.
REQ-020 MULTU SHALL compute the 64-bit unsigned product, with HI = bits [63:32] and LO = bits [31:0].
REQ-021 MULT SHALL operate on magnitudes of the two's-complement operands and negate the 64-bit product when the operand signs differ.
REQ-022 DIVU SHALL produce LO = unsigned quotient and HI = unsigned remainder.
REQ-023 DIV SHALL operate on magnitudes; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend (truncation toward zero).
REQ-024 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0 (wrap, no flag).
REQ-025 DIV/DIVU with `rt_data`=0 SHALL skip iteration: the next edge goes to DONE, `done`=1 and `div_by_zero`=1 for that cycle, and HI/LO are unchanged.
REQ-026 `mthi` or `mtlo` SHALL load `rs_data` into HI or LO at the edge only while in IDLE with `start`=0; they SHALL be ignored in BUSY and DONE.
REQ-027 When `start` and `mthi`/`mtlo` are both asserted in IDLE, `start` SHALL win and the move is dropped.
REQ-028 `mthi` and `mtlo` together SHALL load both HI and LO with `rs_data`.
REQ-029 `busy`=1 in BUSY only; `done` and `div_by_zero`=0 outside DONE.

Reset
REQ-030 On `reset`=1, independent of `clock`, the block SHALL immediately set state = IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0, and the counter and internal operand registers to 0.
REQ-031 A reset asserted mid-operation SHALL abort it with no HI/LO update; after deassertion the first edge with `start` begins a fresh operation.

Verification
REQ-032 The bench SHALL cover: MULTU, `rs_data`=0xFFFFFFFF, `rt_data`=2 -> `done` at edge 33; HI=0x00000001, LO=0xFFFFFFFE; `busy` high for 32 cycles.
REQ-033 The bench SHALL cover: MULT with the same operands -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 The bench SHALL cover: DIV -7 (0xFFFFFFF9) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-035 The bench SHALL cover: mthi with `rs_data`=0x1234 in IDLE, then DIVU 5/0 -> `done` and `div_by_zero` high one cycle after start, HI stays 0x1234, LO stays 0.
REQ-036 The bench SHALL cover: `start` with `mtlo` in the same cycle, then `mtlo` pulsed during BUSY -> LO holds only the operation result.
REQ-037 The bench SHALL cover: `reset` asserted between clock edges at BUSY iteration 10 -> outputs zero immediately, no `done`; a subsequent MULTU 3*4 gives LO=12, HI=0.
